// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM (optional perf counters: MIPS_CTRL_PERF_CNT_EN)
module mips_multicycle_ctrl #(
    parameter int OP_WIDTH    = 6,
    parameter int STATE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_en,
    output logic [1:0]          pc_source,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_code,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         inst_cnt
`endif
);

    typedef enum logic [STATE_WIDTH-1:0] {
        INIT   = STATE_WIDTH'(0),
        FETCH  = STATE_WIDTH'(1),
        DECODE = STATE_WIDTH'(2),
        ADDR   = STATE_WIDTH'(3),
        MEM_RD = STATE_WIDTH'(4),
        MEM_WB = STATE_WIDTH'(5),
        MEM_WR = STATE_WIDTH'(6),
        EXEC   = STATE_WIDTH'(7),
        R_WB   = STATE_WIDTH'(8),
        IMM_WB = STATE_WIDTH'(9),
        BRANCH = STATE_WIDTH'(10),
        JUMP   = STATE_WIDTH'(11)
    } state_t;

    // Control word that depends only on the state; registered alongside it.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_code;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
    localparam logic [OP_WIDTH-1:0] OP_ADDIU = OP_WIDTH'(6'b001001);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_q;

    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE: begin c.alu_src_b = 2'b11; end
            ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEM_RD: begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEM_WB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEM_WR: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            EXEC:   begin c.alu_src_a = 1'b1; c.alu_code = 2'b10; end
            R_WB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            IMM_WB: begin c.reg_write = 1'b1; end
            BRANCH: begin c.alu_src_a = 1'b1; c.alu_code = 2'b01; c.pc_source = 2'b01; end
            JUMP:   begin c.pc_source = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection; memory states hold until the handshake completes.
    always_comb begin
        state_next = INIT;
        case (state)
            INIT:   state_next = FETCH;
            FETCH:  state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (opcode == OP_RTYPE)
                    state_next = EXEC;
                else if (opcode == OP_LW || opcode == OP_SW || opcode == OP_ADDIU)
                    state_next = ADDR;
                else if (opcode == OP_BEQ)
                    state_next = BRANCH;
                else if (opcode == OP_J)
                    state_next = JUMP;
                else
                    state_next = FETCH;
            end
            ADDR: begin
                if (opcode == OP_LW)
                    state_next = MEM_RD;
                else if (opcode == OP_SW)
                    state_next = MEM_WR;
                else
                    state_next = IMM_WB;
            end
            MEM_RD: state_next = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB: state_next = FETCH;
            MEM_WR: state_next = mem_ready ? FETCH : MEM_WR;
            EXEC:   state_next = R_WB;
            R_WB:   state_next = FETCH;
            IMM_WB: state_next = FETCH;
            BRANCH: state_next = FETCH;
            JUMP:   state_next = FETCH;
            default: state_next = INIT;
        endcase
    end

    // State register with the state-decoded control word registered in step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT;
            ctrl_q <= '0;
        end else begin
            state  <= state_next;
            ctrl_q <= decode_state(state_next);
        end
    end

    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign iord       = ctrl_q.iord;
    assign pc_source  = ctrl_q.pc_source;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_code   = ctrl_q.alu_code;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_write  = ctrl_q.reg_write;

    // Fetch completion, branch outcome and opcode legality are only known within the cycle.
    assign ir_write   = (state == FETCH) && mem_ready;
    assign pc_en      = ((state == FETCH) && mem_ready) || (state == JUMP) ||
                        ((state == BRANCH) && zero);
    assign illegal_op = (state == DECODE) &&
                        !(opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
                          opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDIU);

`ifdef MIPS_CTRL_PERF_CNT_EN
    // Active-cycle and retired-instruction counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            if (state != INIT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (state != INIT && state != FETCH && state_next == FETCH)
                inst_cnt <= inst_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_source, alu_src_b, alu_code;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, inst_cnt;
`endif

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_code   (alu_code),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
`ifdef MIPS_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .inst_cnt   (inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bit order: mem_read mem_write iord ir_write pc_en pc_source[2] alu_src_a
    //            alu_src_b[2] alu_code[2] reg_dst mem_to_reg reg_write illegal_op
    logic [15:0] act;
    assign act = {mem_read, mem_write, iord, ir_write, pc_en, pc_source, alu_src_a,
                  alu_src_b, alu_code, reg_dst, mem_to_reg, reg_write, illegal_op};

    localparam logic [15:0] E_ZERO   = 16'h0000;
    localparam logic [15:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_FSTALL = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_DEC_IL = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b1};
    localparam logic [15:0] E_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_MEM_RD = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_MEM_WB = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0};
    localparam logic [15:0] E_MEM_WR = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_R_WB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0};
    localparam logic [15:0] E_IMM_WB = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0};
    localparam logic [15:0] E_BR_T   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_BR_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam logic [15:0] E_JUMP   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};

    typedef struct packed {
        logic [5:0]       op;
        logic             z;
        logic [3:0]       n;
        logic [4:0][15:0] exp;
    } vec_t;

    typedef struct packed {
        logic [15:0] exp;
        logic [15:0] id;
    } sb_t;

    sb_t  sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;
    vec_t vecs[9];

    function automatic vec_t mkvec(input logic [5:0] op, input logic z, input logic [3:0] n,
                                   input logic [15:0] e0, input logic [15:0] e1,
                                   input logic [15:0] e2, input logic [15:0] e3,
                                   input logic [15:0] e4);
        vec_t v;
        v.op = op;
        v.z  = z;
        v.n  = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        return v;
    endfunction

    // Checker: pops one expectation per cycle, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL step%0d ctrl: got %b expected %b", e.id, act, e.exp);
            end
        end
    end

    // Inputs are already set; record the expectation for this cycle and advance.
    task automatic step(input logic [15:0] e);
        sb.push_back({e, 16'(step_id)});
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        for (int c = 0; c < int'(v.n); c++) begin
            opcode    = v.op;
            zero      = v.z;
            mem_ready = 1'b1;
            step(v.exp[c]);
        end
    endtask

    initial begin
        vecs[0] = mkvec(6'b000000, 1'b0, 4'd4, E_FETCH, E_DECODE, E_EXEC, E_R_WB, E_ZERO);
        vecs[1] = mkvec(6'b100011, 1'b1, 4'd5, E_FETCH, E_DECODE, E_ADDR, E_MEM_RD, E_MEM_WB);
        vecs[2] = mkvec(6'b101011, 1'b0, 4'd4, E_FETCH, E_DECODE, E_ADDR, E_MEM_WR, E_ZERO);
        vecs[3] = mkvec(6'b001001, 1'b1, 4'd4, E_FETCH, E_DECODE, E_ADDR, E_IMM_WB, E_ZERO);
        vecs[4] = mkvec(6'b000100, 1'b1, 4'd3, E_FETCH, E_DECODE, E_BR_T, E_ZERO, E_ZERO);
        vecs[5] = mkvec(6'b000100, 1'b0, 4'd3, E_FETCH, E_DECODE, E_BR_N, E_ZERO, E_ZERO);
        vecs[6] = mkvec(6'b000010, 1'b0, 4'd3, E_FETCH, E_DECODE, E_JUMP, E_ZERO, E_ZERO);
        vecs[7] = mkvec(6'b111111, 1'b0, 4'd2, E_FETCH, E_DEC_IL, E_ZERO, E_ZERO, E_ZERO);
        vecs[8] = mkvec(6'b000001, 1'b1, 4'd2, E_FETCH, E_DEC_IL, E_ZERO, E_ZERO, E_ZERO);

        rst = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(E_ZERO);
        rst = 1'b0;
        step(E_ZERO);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fetch stall, then a jump.
        opcode = 6'b000010; zero = 1'b0;
        mem_ready = 1'b0; step(E_FSTALL);
        mem_ready = 1'b0; step(E_FSTALL);
        mem_ready = 1'b1; step(E_FETCH);
        step(E_DECODE);
        step(E_JUMP);

        // lw with three stalled MEM_RD cycles: 8 cycles in total.
        opcode = 6'b100011;
        mem_ready = 1'b1; step(E_FETCH);
        step(E_DECODE);
        step(E_ADDR);
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0;
            step(E_MEM_RD);
        end
        mem_ready = 1'b1; step(E_MEM_RD);
        step(E_MEM_WB);

        // sw: mem_ready ignored in DECODE/ADDR, one stalled MEM_WR cycle.
        opcode = 6'b101011;
        mem_ready = 1'b1; step(E_FETCH);
        mem_ready = 1'b0; step(E_DECODE);
        mem_ready = 1'b0; step(E_ADDR);
        mem_ready = 1'b0; step(E_MEM_WR);
        mem_ready = 1'b1; step(E_MEM_WR);

        // Reset for two cycles in the middle of a stalled MEM_RD.
        opcode = 6'b100011;
        mem_ready = 1'b1; step(E_FETCH);
        step(E_DECODE);
        step(E_ADDR);
        mem_ready = 1'b0; step(E_MEM_RD);
        rst = 1'b1; step(E_MEM_RD);
        step(E_ZERO);
        rst = 1'b0; step(E_ZERO);
        mem_ready = 1'b1; opcode = 6'b000010; step(E_FETCH);
        step(E_DECODE);
        step(E_JUMP);

`ifdef MIPS_CTRL_PERF_CNT_EN
        // Counters from a clean reset: sw, addiu, j back-to-back.
        rst = 1'b1; step(E_FETCH);
        rst = 1'b0; step(E_ZERO);
        run_vec(vecs[2]);
        run_vec(vecs[3]);
        run_vec(vecs[6]);
        @(negedge clk);
        n_checks++;
        if (inst_cnt !== 32'd3) begin
            n_errors++;
            $display("FAIL inst_cnt: got %0d expected 3", inst_cnt);
        end
        n_checks++;
        if (cycle_cnt !== 32'd11) begin
            n_errors++;
            $display("FAIL cycle_cnt: got %0d expected 11", cycle_cnt);
        end
        n_checks++;
        if (act !== E_FETCH) begin
            n_errors++;
            $display("FAIL perf_fetch: got %b expected %b", act, E_FETCH);
        end
`endif

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
